// File: rtl/karatsuba3_mul_pipe_pkg.sv
// Shared constants and helpers for the 3-way Karatsuba multiplier pipeline.
package kara_pkg;

  // Register stages that are not sub-multiplier stages: S1, S2, R1..R4.
  localparam int unsigned KARA_FIXED_STAGES = 6;

  // Limb width: the operand is zero-padded to three equal limbs.
  function automatic int unsigned kara_wayw(input int unsigned idw);
    return (idw + 2) / 3;
  endfunction

  // Input-transfer to o_valid latency in enabled cycles.
  function automatic int unsigned kara_lat(input int unsigned sublat);
    return sublat + KARA_FIXED_STAGES;
  endfunction

endpackage

// File: rtl/karatsuba3_mul_pipe_sub_mul.sv
// Registered unsigned W x W -> 2W multiplier, LAT enabled cycles deep.
module kara_sub_mul
  import kara_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  output logic [2*W-1:0]   o_p
);

  logic [2*W-1:0] r_pipe [LAT];

  // Product enters stage 0 and is shifted down the stall-able delay line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= (2*W)'(i_a) * (2*W)'(i_b);
      for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_p = r_pipe[LAT-1];

endmodule

// File: rtl/karatsuba3_mul_pipe.sv
// Fully pipelined 3-way Karatsuba multiplier, IDW x IDW -> 2*IDW, with
// valid/ready flow control (global stall), tag pass-through and, when the
// KARA_SQR_EN macro is defined, a squaring request (i_sqr) that replaces B
// with A at the first stage.
module karatsuba3_mul_pipe
  import kara_pkg::*;
#(
  parameter int unsigned IDW    = 256,
  parameter int unsigned TAGW   = 8,
  parameter int unsigned SUBLAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IDW-1:0]    i_a,
  input  logic [IDW-1:0]    i_b,
  input  logic [TAGW-1:0]   i_tag,
  input  logic              i_sqr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*IDW-1:0]  o_res,
  output logic [TAGW-1:0]   o_tag
);

  localparam int unsigned WAYW = kara_wayw(IDW);
  localparam int unsigned LAT  = kara_lat(SUBLAT);
  localparam int unsigned XW   = 3 * WAYW;
  localparam int unsigned SW   = WAYW + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned LW   = 2 * IDW + 2;
  localparam int unsigned OW   = 2 * IDW;

  logic                w_en;
  logic [IDW-1:0]      w_b_sel;
  logic [LAT-1:0]      r_vld;
  logic [TAGW-1:0]     r_tag [LAT];
  logic [XW-1:0]       r_a1, r_b1;
  logic [SW-1:0]       w_a_op [6];
  logic [SW-1:0]       w_b_op [6];
  logic [SW-1:0]       r_a2 [6];
  logic [SW-1:0]       r_b2 [6];
  logic [PW-1:0]       w_p [6];
  logic [LW-1:0]       w_pe [6];
  logic [LW-1:0]       w_l [5];
  logic [LW-1:0]       r_l [5];
  logic [LW-1:0]       r_s12, r_s34, r_l5_2, r_s4, r_l5_3;
  logic [OW-1:0]       r_res;

  assign w_en    = !o_valid | i_ready;
  assign o_ready = w_en;
  assign o_valid = r_vld[LAT-1];
  assign o_tag   = r_tag[LAT-1];
  assign o_res   = r_res;

`ifdef KARA_SQR_EN
  assign w_b_sel = i_sqr ? i_a : i_b;
`else
  logic w_unused_sqr;
  assign w_unused_sqr = i_sqr;
  assign w_b_sel      = i_b;
`endif

  // Valid/tag shift chain, LAT deep, aligned with the data stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else if (w_en) begin
      r_vld    <= {r_vld[LAT-2:0], i_valid};
      r_tag[0] <= i_tag;
      for (int unsigned i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // S1: capture zero-extended operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a1 <= '0;
      r_b1 <= '0;
    end else if (w_en) begin
      r_a1 <= XW'(i_a);
      r_b1 <= XW'(w_b_sel);
    end
  end

  // Split into limbs and form pairwise limb sums (index 3: x1+x0, 4: x2+x0, 5: x2+x1).
  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      w_a_op[k] = SW'(r_a1[k*WAYW +: WAYW]);
      w_b_op[k] = SW'(r_b1[k*WAYW +: WAYW]);
    end
    w_a_op[3] = w_a_op[1] + w_a_op[0];
    w_b_op[3] = w_b_op[1] + w_b_op[0];
    w_a_op[4] = w_a_op[2] + w_a_op[0];
    w_b_op[4] = w_b_op[2] + w_b_op[0];
    w_a_op[5] = w_a_op[2] + w_a_op[1];
    w_b_op[5] = w_b_op[2] + w_b_op[1];
  end

  // S2: register limbs and limb sums as sub-multiplier operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < 6; k++) begin
        r_a2[k] <= '0;
        r_b2[k] <= '0;
      end
    end else if (w_en) begin
      for (int unsigned k = 0; k < 6; k++) begin
        r_a2[k] <= w_a_op[k];
        r_b2[k] <= w_b_op[k];
      end
    end
  end

  // Products: 0 p00, 1 p11, 2 p22, 3 p10s, 4 p20s, 5 p21s.
  for (genvar g = 0; g < 6; g++) begin : g_mul
    kara_sub_mul #(.W(SW), .LAT(SUBLAT)) u_mul (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_en),
      .i_a   (r_a2[g]),
      .i_b   (r_b2[g]),
      .o_p   (w_p[g])
    );
  end

  // Recombine into five shifted lines; the differences are non-negative,
  // and wrap-around beyond LW bits cancels since the true product fits.
  always_comb begin
    for (int unsigned k = 0; k < 6; k++) w_pe[k] = LW'(w_p[k]);
    w_l[0] = w_pe[0];
    w_l[1] = (w_pe[3] - w_pe[1] - w_pe[0]) << WAYW;
    w_l[2] = (w_pe[4] - w_pe[2] - w_pe[0] + w_pe[1]) << (2*WAYW);
    w_l[3] = (w_pe[5] - w_pe[2] - w_pe[1]) << (3*WAYW);
    w_l[4] = w_pe[2] << (4*WAYW);
  end

  // R1..R4: line registers, then a three-level adder tree into o_res.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < 5; k++) r_l[k] <= '0;
      r_s12  <= '0;
      r_s34  <= '0;
      r_l5_2 <= '0;
      r_s4   <= '0;
      r_l5_3 <= '0;
      r_res  <= '0;
    end else if (w_en) begin
      for (int unsigned k = 0; k < 5; k++) r_l[k] <= w_l[k];
      r_s12  <= r_l[0] + r_l[1];
      r_s34  <= r_l[2] + r_l[3];
      r_l5_2 <= r_l[4];
      r_s4   <= r_s12 + r_s34;
      r_l5_3 <= r_l5_2;
      r_res  <= OW'(r_s4 + r_l5_3);
    end
  end

endmodule

// File: tb/tb_karatsuba3_mul_pipe.sv
// Self-checking bench for karatsuba3_mul_pipe: scoreboard model plus directed
// literal checks; two narrow instances cover IDW=64 and padded IDW=100.
module tb_karatsuba3_mul_pipe;

  localparam int unsigned IDW  = 256;
  localparam int unsigned TAGW = 8;

  typedef struct {
    logic [511:0] res;
    logic [7:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst, i_valid, i_ready, i_sqr;
  logic [IDW-1:0]    i_a, i_b;
  logic [TAGW-1:0]   i_tag;
  logic              o_ready, o_valid;
  logic [2*IDW-1:0]  o_res;
  logic [TAGW-1:0]   o_tag;

  logic              s_valid, s_ready;
  logic [7:0]        s_tag;
  logic [63:0]       s_a64;
  logic [99:0]       s_a100;
  logic              s64_ready, s64_valid, s100_ready, s100_valid;
  logic [127:0]      s64_res;
  logic [199:0]      s100_res;
  logic [7:0]        s64_tag, s100_tag;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;
  exp_t        q[$];

  karatsuba3_mul_pipe #(.IDW(IDW), .TAGW(TAGW), .SUBLAT(2)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .i_sqr(i_sqr),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_tag(o_tag)
  );

  karatsuba3_mul_pipe #(.IDW(64), .TAGW(8), .SUBLAT(2)) u_d64 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(s_valid), .o_ready(s64_ready),
    .i_a(s_a64), .i_b(s_a64), .i_tag(s_tag), .i_sqr(1'b0),
    .o_valid(s64_valid), .i_ready(s_ready), .o_res(s64_res), .o_tag(s64_tag)
  );

  karatsuba3_mul_pipe #(.IDW(100), .TAGW(8), .SUBLAT(2)) u_d100 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(s_valid), .o_ready(s100_ready),
    .i_a(s_a100), .i_b(s_a100), .i_tag(s_tag), .i_sqr(1'b0),
    .o_valid(s100_valid), .i_ready(s_ready), .o_res(s100_res), .o_tag(s100_tag)
  );

  task automatic check(input string name, input logic ok,
                       input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b);
    return {256'b0, a} * {256'b0, b};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // Scoreboard: record accepted inputs, compare every accepted output.
  logic         prev_hold = 1'b0;
  logic [511:0] prev_res;
  logic [7:0]   prev_tag;
  always @(negedge clk) begin
    exp_t         e;
    logic [255:0] bsel;
    if (i_rst) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check("ready_rule", o_ready === (!o_valid || i_ready), 512'(o_ready),
            512'(!o_valid || i_ready));
      if (prev_hold) begin
        check("hold_valid", o_valid === 1'b1, 512'(o_valid), 512'(1));
        check("hold_res", o_res === prev_res, o_res, prev_res);
        check("hold_tag", o_tag === prev_tag, 512'(o_tag), 512'(prev_tag));
      end
      prev_hold = o_valid && !i_ready;
      prev_res  = o_res;
      prev_tag  = o_tag;
      if (i_valid && o_ready) begin
`ifdef KARA_SQR_EN
        bsel = i_sqr ? i_a : i_b;
`else
        bsel = i_b;
`endif
        e.res = model(i_a, bsel);
        e.tag = i_tag;
        q.push_back(e);
      end
      if (o_valid && i_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_output", 1'b0, o_res, 512'(0));
        end else begin
          e = q.pop_front();
          check("res", o_res === e.res, o_res, e.res);
          check("tag", o_tag === e.tag, 512'(o_tag), 512'(e.tag));
        end
      end
    end
  end

  // Present one operation and hold it until accepted.
  task automatic send(input logic [255:0] a, input logic [255:0] b,
                      input logic [7:0] t, input logic s);
    logic ok = 1'b0;
    i_valid = 1'b1; i_a = a; i_b = b; i_tag = t; i_sqr = s;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", ok, 512'(ok), 512'(1));
    i_valid = 1'b0; i_sqr = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned edges);
    edges = 1;
    for (int k = 0; k < 40 && !o_valid; k++) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("wait_valid", o_valid === 1'b1, 512'(o_valid), 512'(1));
  endtask

  task automatic drain(input int unsigned cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned  edges, n0;
    logic [511:0] lit;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_sqr = 1'b0;
    i_a = '0; i_b = '0; i_tag = '0;
    s_valid = 1'b0; s_ready = 1'b1; s_tag = '0; s_a64 = '0; s_a100 = '0;

    check("model_pin", model(256'h1234, 256'hFFFF) === 512'h1233EDCC,
          model(256'h1234, 256'hFFFF), 512'h1233EDCC);

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid === 1'b0, 512'(o_valid), 512'(0));
    check("rst_res", o_res === '0, o_res, 512'(0));
    check("rst_tag", o_tag === '0, 512'(o_tag), 512'(0));
    check("rst_ready", o_ready === 1'b1, 512'(o_ready), 512'(1));
    i_rst = 1'b0;

    // 2*3 with latency measurement
    send(256'd2, 256'd3, 8'hA5, 1'b0);
    wait_valid(edges);
    check("latency", edges == 8, 512'(edges), 512'(8));
    check("res_2x3", o_res === 512'd6, o_res, 512'd6);
    check("tag_2x3", o_tag === 8'hA5, 512'(o_tag), 512'hA5);
    drain(2);

    // all-ones operands, IDW=256
    send('1, '1, 8'h11, 1'b0);
    wait_valid(edges);
    lit = {{255{1'b1}}, {256{1'b0}}, 1'b1};
    check("ones_256", o_res === lit, o_res, lit);
    drain(2);

    // all-ones on the narrow instances
    s_valid = 1'b1; s_a64 = '1; s_a100 = '1; s_tag = 8'h5C;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 40 && !(s64_valid && s100_valid); k++) begin
      @(posedge clk); #1;
    end
    lit = 512'({{63{1'b1}}, {64{1'b0}}, 1'b1});
    check("ones_64", s64_res === lit[127:0], 512'(s64_res), lit);
    check("tag_64", s64_tag === 8'h5C, 512'(s64_tag), 512'h5C);
    lit = 512'({{99{1'b1}}, {100{1'b0}}, 1'b1});
    check("ones_100", s100_res === lit[199:0], 512'(s100_res), lit);
    check("tag_100", s100_tag === 8'h5C, 512'(s100_tag), 512'h5C);

    // zero operand
    send('0, rnd256(), 8'h22, 1'b0);
    wait_valid(edges);
    check("zero", o_res === '0, o_res, 512'(0));
    drain(2);

    // square request
    send(256'h1234, 256'hFFFF, 8'h33, 1'b1);
    wait_valid(edges);
`ifdef KARA_SQR_EN
    check("sqr", o_res === 512'h14B5A90, o_res, 512'h14B5A90);
`else
    check("sqr_ignored", o_res === 512'h1233EDCC, o_res, 512'h1233EDCC);
`endif
    drain(2);

    // 20 back-to-back random pairs
    n0 = n_out;
    for (int i = 0; i < 20; i++) send(rnd256(), rnd256(), 8'(i + 16), 1'b0);
    drain(20);
    check("b2b_count", n_out - n0 == 20, 512'(n_out - n0), 512'(20));

    // output stall of 5 cycles after the first result
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) send(rnd256(), rnd256(), 8'(i + 64), 1'b0);
      end
      begin
        for (int k = 0; k < 60 && !o_valid; k++) begin
          @(posedge clk); #1;
        end
        i_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("stall_ready", o_ready === 1'b0, 512'(o_ready), 512'(0));
          check("stall_valid", o_valid === 1'b1, 512'(o_valid), 512'(1));
        end
        i_ready = 1'b1;
      end
    join
    drain(20);
    check("stall_count", n_out - n0 == 10, 512'(n_out - n0), 512'(10));

    // reset with four operations in flight
    for (int i = 0; i < 4; i++) send(rnd256(), rnd256(), 8'(i + 128), 1'b0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", o_valid === 1'b0, 512'(o_valid), 512'(0));
    check("midrst_res", o_res === '0, o_res, 512'(0));
    check("midrst_ready", o_ready === 1'b1, 512'(o_ready), 512'(1));
    i_rst = 1'b0;
    n0 = n_out;
    drain(20);
    check("midrst_none", n_out == n0, 512'(n_out - n0), 512'(0));

    check("scoreboard_empty", q.size() == 0, 512'(q.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
